apb_gpio_arb: RTL and testbench
===============================

# apb_gpio_arb

Two-port APB arbiter that shares the single APB slave port of the GPIO peripheral between two APB masters (e.g. core and debug/DMA). It arbitrates round-robin per transfer, serialises whole APB transfers onto the slave port, and stalls the losing master with PREADY low. It guarantees exactly one slave access phase per granted transfer. This matters because the GPIO clears its interrupt on an INTSTATUS read.

## Interface
- APB_ADDR_WIDTH, 12: address width on all three APB ports.
- HCLK  in  1  clock; all state on rising edge.
- HRESETn  in  1  reset; asynchronous assert, active-low.
- m0_PADDR / m1_PADDR  in  APB_ADDR_WIDTH  master address.
- m0_PWDATA / m1_PWDATA  in  32  master write data.
- m0_PWRITE / m1_PWRITE  in  1  1 = write.
- m0_PSEL / m1_PSEL  in  1  master select; this is the request.
- m0_PENABLE / m1_PENABLE  in  1  master access phase.
- m0_PRDATA / m1_PRDATA  out  32  read data; 0 when the port is not completing.
- m0_PREADY / m1_PREADY  out  1  transfer complete; low while waiting or not granted.
- m0_PSLVERR / m1_PSLVERR  out  1  slave error; valid only with PREADY, 0 otherwise.
- s_PADDR  out  APB_ADDR_WIDTH  to the GPIO slave; registered.
- s_PWDATA  out  32  registered.
- s_PWRITE  out  1  registered.
- s_PSEL  out  1  registered.
- s_PENABLE  out  1  registered.
- s_PRDATA  in  32  slave read data.
- s_PREADY  in  1  slave ready.
- s_PSLVERR  in  1  slave error.
- grant  out  2  one-hot owner of the current transfer; 2'b00 in IDLE.

## Operation
FSM states: IDLE, SETUP, ACCESS. A state register `last` holds the index of the last granted master.

- **IDLE**
  - req[i] = mi_PSEL.
  - If no request: stay in IDLE.
  - One request: grant that master.
  - Both requesting: grant the master that is not `last`.
  - On grant: capture that master's PADDR/PWDATA/PWRITE into the s_* registers, set s_PSEL=1, s_PENABLE=0, go to SETUP.
- **SETUP**: set s_PENABLE=1 and go to ACCESS. s_PSEL stays 1 and the captured fields hold.
- **ACCESS**
  - If s_PREADY=0: stay in ACCESS with all s_* outputs held.
  - If s_PREADY=1, the granted master gets, combinationally in the same cycle, mi_PREADY=1, mi_PRDATA=s_PRDATA and mi_PSLVERR=s_PSLVERR.
  - Also on s_PREADY=1: update `last` to the granted master, clear s_PSEL and s_PENABLE, go to IDLE.
- Master side:
  - The master is required to hold PADDR/PWDATA/PWRITE/PSEL stable until its PREADY.
  - The arbiter does not re-sample master fields after capture.
  - The master's PENABLE is not checked. The arbiter's own SETUP cycle guarantees the master is in its access phase before completion.
- The non-granted master always sees PREADY=0, PRDATA=0 and PSLVERR=0, whatever the slave does.
- Outputs are never left undriven; s_PADDR/s_PWDATA/s_PWRITE keep their last value in IDLE.

## Timing
- Reset values:
  - state=IDLE, `last`=1 (so m0 wins the first tie), grant=00.
  - s_PSEL=0, s_PENABLE=0, s_PWRITE=0, s_PADDR=0, s_PWDATA=0.
  - All m*_PREADY=0, m*_PRDATA=0, m*_PSLVERR=0.
- Uncontended transfer with zero-wait slave: master PSEL rises in cycle 0 (IDLE) → s_PSEL=1 in cycle 1 → s_PENABLE=1 in cycle 2 → mi_PREADY=1 in cycle 2. That is 3 cycles, one wait state more than a direct connection.
- Slave wait states add one cycle each, 1:1.
- A new transfer can start in the IDLE cycle right after completion, so the minimum spacing is 3 cycles per transfer.
- Both masters continuously requesting: grants alternate m0, m1, m0, … with no starvation. The worst-case wait for a master is one other transfer plus its own.
- A request that drops in IDLE before grant is ignored. A request that drops after grant is a protocol violation; the transfer still completes on the slave.
- HRESETn asserted mid-transfer (SETUP or ACCESS): immediate return to reset values. The slave access is aborted and no PREADY is issued to the master.

## Test plan
- Reset then m0 single write (PADDR=0x010, PWDATA=0xA5A5_0001) → s_PSEL high cycle 1, s_PENABLE cycle 2, m0_PREADY=1 cycle 2 only, GPIO PADOUT reads back 0xA5A5_0001; m1_PREADY stays 0.
- m0 and m1 both request in the same cycle after reset (m0 read 0x008, m1 write 0x008=0xFF) → m0 served first, then m1; the next simultaneous pair serves m1 first only if m0 was last; grant sequence 01,10.
- Both masters stream 8 back-to-back reads → grants strictly alternate, each completion 3 cycles apart, 16 completions in 48 cycles.
- INTSTATUS read contention: interrupt pending, m0 and m1 both read 0x020 → exactly one s_PENABLE pulse per transfer; first reader gets PRDATA=1, second gets 0; interrupt deasserts once.
- Slave with 2 wait states (s_PREADY low 2 cycles) and s_PSLVERR=1 → m1_PREADY and m1_PSLVERR high together in cycle 4 only; s_* fields stable throughout ACCESS.
- HRESETn pulsed low during ACCESS of an m1 write → s_PSEL/s_PENABLE=0 asynchronously, no m1_PREADY, grant=00. After release a simultaneous request grants m0.

Source files
------------

// File: rtl/apb_gpio_arb_if.sv
// APB bus bundle shared by both master ports and the GPIO slave port of apb_gpio_arb.
// The master modport is the initiator's view; the slave modport is the target's view.
interface apb_gpio_arb_if #(
    parameter int unsigned APB_ADDR_WIDTH = 12
) ();
    localparam int unsigned DATA_W = 32;

    logic [APB_ADDR_WIDTH-1:0] PADDR;
    logic [DATA_W-1:0]         PWDATA;
    logic                      PWRITE;
    logic                      PSEL;
    logic                      PENABLE;
    logic [DATA_W-1:0]         PRDATA;
    logic                      PREADY;
    logic                      PSLVERR;

    modport master (
        output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_gpio_arb.sv
// Round-robin arbiter sharing one APB GPIO slave between two APB masters.
// Whole transfers are serialised so each granted transfer makes exactly one slave access.
module apb_gpio_arb #(
    parameter int unsigned APB_ADDR_WIDTH = 12
) (
    input  logic                HCLK,
    input  logic                HRESETn,
    apb_gpio_arb_if.slave       m0,
    apb_gpio_arb_if.slave       m1,
    apb_gpio_arb_if.master      s,
    output logic [1:0]          grant
);
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

    typedef struct packed {
        logic [APB_ADDR_WIDTH-1:0] addr;
        logic [DATA_W-1:0]         wdata;
        logic                      write;
    } req_t;

    state_e     state_q, state_d;
    logic       last_q, last_d;
    logic       owner_q, owner_d;
    logic [1:0] grant_q, grant_d;
    req_t       req_q, req_d;
    logic       psel_q, psel_d;
    logic       penable_q, penable_d;
    logic       pick_c;
    logic       done_c;

    // Master PENABLE is deliberately ignored; the SETUP cycle covers the access phase.
    logic unused_penable_c;
    assign unused_penable_c = m0.PENABLE ^ m1.PENABLE;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            owner_q   <= 1'b0;
            grant_q   <= 2'b00;
            req_q     <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            owner_q   <= owner_d;
            grant_q   <= grant_d;
            req_q     <= req_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        owner_d   = owner_q;
        grant_d   = grant_q;
        req_d     = req_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        pick_c    = 1'b0;
        done_c    = 1'b0;

        case (state_q)
            IDLE: begin
                // On a tie the master that was not served last wins.
                pick_c = (m0.PSEL && m1.PSEL) ? ~last_q : m1.PSEL;
                if (m0.PSEL || m1.PSEL) begin
                    owner_d   = pick_c;
                    grant_d   = pick_c ? 2'b10 : 2'b01;
                    if (pick_c) begin
                        req_d = '{addr: m1.PADDR, wdata: m1.PWDATA, write: m1.PWRITE};
                    end else begin
                        req_d = '{addr: m0.PADDR, wdata: m0.PWDATA, write: m0.PWRITE};
                    end
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (s.PREADY) begin
                    done_c    = 1'b1;
                    last_d    = owner_q;
                    grant_d   = 2'b00;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Completion is routed combinationally to the owner only; the other port reads zero.
    assign m0.PREADY  = done_c && !owner_q;
    assign m0.PRDATA  = (done_c && !owner_q) ? s.PRDATA : '0;
    assign m0.PSLVERR = done_c && !owner_q && s.PSLVERR;
    assign m1.PREADY  = done_c && owner_q;
    assign m1.PRDATA  = (done_c && owner_q) ? s.PRDATA : '0;
    assign m1.PSLVERR = done_c && owner_q && s.PSLVERR;

    assign s.PADDR   = req_q.addr;
    assign s.PWDATA  = req_q.wdata;
    assign s.PWRITE  = req_q.write;
    assign s.PSEL    = psel_q;
    assign s.PENABLE = penable_q;
    assign grant     = grant_q;
endmodule

// File: tb/tb_apb_gpio_arb.sv
// Bench for apb_gpio_arb: directed vector table, hand-written corner sequences and a
// randomized run checked against a transfer-level timeline model with a GPIO-like slave.
module tb_apb_gpio_arb;
    localparam int unsigned AW = 12;

    logic       HCLK = 1'b0;
    logic       HRESETn;
    logic [1:0] grant;

    apb_gpio_arb_if #(.APB_ADDR_WIDTH(AW)) m0_if ();
    apb_gpio_arb_if #(.APB_ADDR_WIDTH(AW)) m1_if ();
    apb_gpio_arb_if #(.APB_ADDR_WIDTH(AW)) s_if ();

    apb_gpio_arb #(.APB_ADDR_WIDTH(AW)) dut (
        .HCLK   (HCLK),
        .HRESETn(HRESETn),
        .m0     (m0_if),
        .m1     (m1_if),
        .s      (s_if),
        .grant  (grant)
    );

    always #5 HCLK = ~HCLK;

    // Master drivers
    logic          m_sel  [2];
    logic          m_en   [2];
    logic          m_wr   [2];
    logic [AW-1:0] m_addr [2];
    logic [31:0]   m_data [2];
    assign m0_if.PSEL = m_sel[0];  assign m0_if.PENABLE = m_en[0];  assign m0_if.PWRITE = m_wr[0];
    assign m0_if.PADDR = m_addr[0]; assign m0_if.PWDATA = m_data[0];
    assign m1_if.PSEL = m_sel[1];  assign m1_if.PENABLE = m_en[1];  assign m1_if.PWRITE = m_wr[1];
    assign m1_if.PADDR = m_addr[1]; assign m1_if.PWDATA = m_data[1];

    logic [1:0]  rdy;
    logic [1:0]  err;
    logic [31:0] rdata [2];
    assign rdy = {m1_if.PREADY, m0_if.PREADY};
    assign err = {m1_if.PSLVERR, m0_if.PSLVERR};
    assign rdata[0] = m0_if.PRDATA;
    assign rdata[1] = m1_if.PRDATA;

    // GPIO-like slave: word memory, INTSTATUS at 0x020 cleared by a read, PSLVERR on addr[11]
    logic [31:0] slv_mem [32] = '{default: 32'h0};
    logic        irq = 1'b0;
    logic        irq_arm = 1'b0;
    logic        pen_prev = 1'b0;
    int          slv_waits = 0;
    int          acc_cnt = 0;
    int          pulses = 0;
    int          slv_done = 0;
    logic [4:0]  s_idx;
    assign s_idx        = s_if.PADDR[6:2];
    assign s_if.PREADY  = s_if.PSEL && s_if.PENABLE && (acc_cnt == slv_waits);
    assign s_if.PRDATA  = (s_if.PADDR == 12'h020) ? {31'b0, irq} : slv_mem[s_idx];
    assign s_if.PSLVERR = s_if.PADDR[11];

    always @(posedge HCLK) begin
        pen_prev <= s_if.PENABLE;
        if (s_if.PENABLE && !pen_prev) pulses <= pulses + 1;
        if (s_if.PSEL && s_if.PENABLE && !s_if.PREADY) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
        if (s_if.PSEL && s_if.PENABLE && s_if.PREADY) begin
            slv_done <= slv_done + 1;
            if (s_if.PWRITE) slv_mem[s_idx] <= s_if.PWDATA;
            else if (s_if.PADDR == 12'h020) irq <= 1'b0;
        end else if (irq_arm) begin
            irq <= 1'b1;
        end
    end

    int n_checks = 0;
    int n_err = 0;
    logic [31:0] ref_mem [32];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_masters();
        for (int i = 0; i < 2; i++) begin
            m_sel[i] = 1'b0; m_en[i] = 1'b0; m_wr[i] = 1'b0; m_addr[i] = '0; m_data[i] = '0;
        end
    endtask

    task automatic do_reset();
        HRESETn = 1'b0;
        idle_masters();
        repeat (2) @(posedge HCLK);
        #1 HRESETn = 1'b1;
    endtask

    typedef struct {
        bit          rst;
        bit          irq;
        logic [1:0]  req;
        int          waits;
        logic        w0; logic [AW-1:0] a0; logic [31:0] d0;
        logic        w1; logic [AW-1:0] a1; logic [31:0] d1;
        logic [1:0]  first;
        logic [31:0] r0, r1;
        logic        e0, e1;
        int          lat0, lat1;
    } vec_t;

    task automatic run_vec(input vec_t v, input int k);
        int          c;
        int          p0;
        logic [1:0]  done;
        logic        w [2];
        logic [31:0] r [2];
        logic        e [2];
        int          lat [2];
        w[0] = v.w0; w[1] = v.w1; r[0] = v.r0; r[1] = v.r1;
        e[0] = v.e0; e[1] = v.e1; lat[0] = v.lat0; lat[1] = v.lat1;
        if (v.rst) do_reset();
        slv_waits = v.waits;
        if (v.irq) begin
            irq_arm = 1'b1;
            @(posedge HCLK);
            #1 irq_arm = 1'b0;
        end
        p0 = pulses;
        m_sel[0] = v.req[0]; m_en[0] = 1'b0; m_wr[0] = v.w0; m_addr[0] = v.a0; m_data[0] = v.d0;
        m_sel[1] = v.req[1]; m_en[1] = 1'b0; m_wr[1] = v.w1; m_addr[1] = v.a1; m_data[1] = v.d1;
        done = ~v.req;
        c = 0;
        while (done != 2'b11 && c < 40) begin
            @(negedge HCLK);
            if (c == 1) begin
                check($sformatf("v%0d first grant", k), 64'(grant), 64'(v.first));
                check($sformatf("v%0d setup psel/penable", k), 64'({s_if.PSEL, s_if.PENABLE}), 64'(2'b10));
            end
            if (c == 2) check($sformatf("v%0d access penable", k), 64'(s_if.PENABLE), 64'(1));
            check($sformatf("v%0d stray pready", k), 64'(rdy & done), 64'(0));
            for (int i = 0; i < 2; i++) begin
                if (rdy[i] && !done[i]) begin
                    check($sformatf("v%0d m%0d latency", k, i), 64'(c), 64'(lat[i]));
                    check($sformatf("v%0d m%0d pslverr", k, i), 64'(err[i]), 64'(e[i]));
                    check($sformatf("v%0d m%0d grant", k, i), 64'(grant), 64'(i == 0 ? 2'b01 : 2'b10));
                    if (!w[i]) check($sformatf("v%0d m%0d prdata", k, i), 64'(rdata[i]), 64'(r[i]));
                    done[i] = 1'b1;
                end
            end
            @(posedge HCLK);
            #1;
            for (int i = 0; i < 2; i++) begin
                if (done[i]) begin m_sel[i] = 1'b0; m_en[i] = 1'b0; end
                else m_en[i] = m_sel[i];
            end
            c++;
        end
        check($sformatf("v%0d all completed", k), 64'(done), 64'(2'b11));
        check($sformatf("v%0d penable pulses", k), 64'(pulses - p0), 64'(v.req[0] + v.req[1]));
        if (v.irq) check($sformatf("v%0d irq cleared", k), 64'(irq), 64'(0));
    endtask

    // Transfer-level timeline model: a grant in an IDLE cycle is followed by one SETUP
    // cycle and completes 2+waits cycles after the grant; ties go to the master not served last.
    task automatic run_random(input int waits, input int ncyc);
        bit          busy = 0;
        int          owner = 0, el = 0, last = 1, n_done = 0, slv0;
        logic        mw = 1'b0, done_now;
        logic [AW-1:0] ma = '0;
        logic [31:0] md = '0, exp_rd;
        logic [1:0]  exp_rdy, rdy_s;
        int          idx;
        do_reset();
        slv_waits = waits;
        slv0 = slv_done;
        for (int cyc = 0; cyc < ncyc + 30; cyc++) begin
            @(negedge HCLK);
            done_now = busy && (el == 2 + waits);
            exp_rdy  = done_now ? (owner == 1 ? 2'b10 : 2'b01) : 2'b00;
            exp_rd   = ref_mem[ma[6:2]];
            check("rnd grant", 64'(grant), 64'(busy ? (owner == 1 ? 2'b10 : 2'b01) : 2'b00));
            check("rnd s_psel/penable", 64'({s_if.PSEL, s_if.PENABLE}), 64'({busy, busy && el >= 2}));
            check("rnd pready", 64'(rdy), 64'(exp_rdy));
            check("rnd prdata m0", 64'(rdata[0]), 64'(exp_rdy[0] ? exp_rd : 32'h0));
            check("rnd prdata m1", 64'(rdata[1]), 64'(exp_rdy[1] ? exp_rd : 32'h0));
            check("rnd pslverr", 64'(err), 64'(exp_rdy & {2{ma[11]}}));
            if (done_now) begin
                if (mw) ref_mem[ma[6:2]] = md;
                last = owner; busy = 0; n_done++;
            end else if (busy) begin
                el++;
            end else if (m_sel[0] || m_sel[1]) begin
                owner = (m_sel[0] && m_sel[1]) ? 1 - last : (m_sel[1] ? 1 : 0);
                mw = m_wr[owner]; ma = m_addr[owner]; md = m_data[owner];
                busy = 1; el = 1;
            end
            rdy_s = rdy;
            @(posedge HCLK);
            #1;
            for (int i = 0; i < 2; i++) begin
                if ((m_sel[i] && rdy_s[i] && cyc < ncyc && $urandom_range(1, 0) == 1) ||
                    (!m_sel[i] && cyc < ncyc && $urandom_range(2, 0) == 0)) begin
                    idx = $urandom_range(31, 16);
                    m_addr[i] = {($urandom_range(3, 0) == 0), 4'b0, 5'(idx), 2'b00};
                    m_wr[i] = 1'($urandom_range(1, 0)); m_data[i] = $urandom;
                    m_sel[i] = 1'b1; m_en[i] = 1'b0;
                end else if (m_sel[i] && rdy_s[i]) begin
                    m_sel[i] = 1'b0; m_en[i] = 1'b0;
                end else begin
                    m_en[i] = m_sel[i];
                end
            end
        end
        check("rnd drained", 64'({busy, m_sel[1], m_sel[0]}), 64'(0));
        check("rnd slave access count", 64'(slv_done - slv0), 64'(n_done));
    endtask

    vec_t vecs [9];
    vec_t post;
    int   comp, c;
    int   remaining [2];

    initial begin
        for (int i = 0; i < 32; i++) ref_mem[i] = 32'h0;
        idle_masters();
        HRESETn = 1'b1;
        #1 HRESETn = 1'b0;
        repeat (2) @(posedge HCLK);
        #1;
        check("reset grant", 64'(grant), 64'(0));
        check("reset s_psel/penable/pwrite", 64'({s_if.PSEL, s_if.PENABLE, s_if.PWRITE}), 64'(0));
        check("reset s_paddr", 64'(s_if.PADDR), 64'(0));
        check("reset s_pwdata", 64'(s_if.PWDATA), 64'(0));
        check("reset master pready/pslverr", 64'({rdy, err}), 64'(0));
        check("reset master prdata", 64'({rdata[1], rdata[0]}), 64'(0));

        //          rst irq req  w  w0 a0      d0            w1 a1      d1          first  r0            r1            e0 e1 lat0 lat1
        vecs[0] = '{1, 0, 2'b01, 0, 1, 12'h010, 32'hA5A5_0001, 0, 12'h000, 32'h0,     2'b01, 32'h0,         32'h0,         0, 0, 2, 0};
        vecs[1] = '{0, 0, 2'b01, 0, 0, 12'h010, 32'h0,         0, 12'h000, 32'h0,     2'b01, 32'hA5A5_0001, 32'h0,         0, 0, 2, 0};
        vecs[2] = '{1, 0, 2'b11, 0, 0, 12'h008, 32'h0,         1, 12'h008, 32'hFF,    2'b01, 32'h0,         32'h0,         0, 0, 2, 5};
        vecs[3] = '{0, 0, 2'b11, 0, 0, 12'h008, 32'h0,         0, 12'h010, 32'h0,     2'b01, 32'hFF,        32'hA5A5_0001, 0, 0, 2, 5};
        vecs[4] = '{0, 0, 2'b01, 0, 1, 12'h00C, 32'h1234,      0, 12'h000, 32'h0,     2'b01, 32'h0,         32'h0,         0, 0, 2, 0};
        vecs[5] = '{0, 0, 2'b11, 0, 0, 12'h00C, 32'h0,         0, 12'h00C, 32'h0,     2'b10, 32'h1234,      32'h1234,      0, 0, 5, 2};
        vecs[6] = '{0, 0, 2'b10, 2, 0, 12'h000, 32'h0,         1, 12'h814, 32'hDEAD,  2'b10, 32'h0,         32'h0,         0, 1, 0, 4};
        vecs[7] = '{0, 0, 2'b11, 1, 0, 12'h014, 32'h0,         0, 12'h810, 32'h0,     2'b01, 32'hDEAD,      32'hA5A5_0001, 0, 1, 3, 7};
        vecs[8] = '{0, 1, 2'b11, 0, 0, 12'h020, 32'h0,         0, 12'h020, 32'h0,     2'b01, 32'h1,         32'h0,         0, 0, 2, 5};
        for (int k = 0; k < 9; k++) run_vec(vecs[k], k);

        // Both masters stream 8 reads: strict alternation, one completion every 3 cycles
        do_reset();
        slv_waits = 0;
        m_sel[0] = 1'b1; m_addr[0] = 12'h010;
        m_sel[1] = 1'b1; m_addr[1] = 12'h008;
        remaining[0] = 8; remaining[1] = 8;
        comp = 0; c = 0;
        while (comp < 16 && c < 60) begin
            @(negedge HCLK);
            if (rdy != 2'b00) begin
                check($sformatf("stream owner %0d", comp), 64'(rdy), 64'(comp % 2 == 1 ? 2'b10 : 2'b01));
                check($sformatf("stream cycle %0d", comp), 64'(c), 64'(2 + 3 * comp));
                if (rdy[0]) remaining[0]--;
                if (rdy[1]) remaining[1]--;
                comp++;
            end
            @(posedge HCLK);
            #1;
            for (int i = 0; i < 2; i++) if (remaining[i] <= 0) m_sel[i] = 1'b0;
            c++;
        end
        check("stream completions", 64'(comp), 64'(16));

        // Reset during ACCESS of an m1 write aborts it without PREADY
        do_reset();
        slv_waits = 3;
        m_sel[1] = 1'b1; m_wr[1] = 1'b1; m_addr[1] = 12'h018; m_data[1] = 32'h5555;
        repeat (3) @(posedge HCLK);
        #2;
        check("abort in access", 64'({grant, s_if.PENABLE}), 64'({2'b10, 1'b1}));
        HRESETn = 1'b0;
        #1;
        check("abort s_psel/penable", 64'({s_if.PSEL, s_if.PENABLE}), 64'(0));
        check("abort grant", 64'(grant), 64'(0));
        m_sel[1] = 1'b0;
        repeat (3) begin
            @(negedge HCLK);
            check("abort no pready", 64'(rdy), 64'(0));
        end
        @(posedge HCLK);
        #1 HRESETn = 1'b1;
        check("abort no slave write", 64'(slv_mem[6]), 64'(0));
        post = '{0, 0, 2'b11, 0, 0, 12'h010, 32'h0, 0, 12'h010, 32'h0,
                 2'b01, 32'hA5A5_0001, 32'hA5A5_0001, 0, 0, 2, 5};
        run_vec(post, 9);

        run_random(0, 400);
        run_random(1, 300);
        run_random(3, 300);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
